req_arbiter_8: RTL and testbench



---
 rtl/req_arbiter_8.sv | 115 +++++++++++
 tb/tb_req_arbiter_8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_8.sv
// req_arbiter_8: 8-way round-robin arbiter with registered one-hot grant,
// hold-while-requesting and optional forced rotation after MAX_HOLD cycles.
module req_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [2:0]    idx_n;
    logic [2:0]    win;
    logic [2:0]    scan;
    logic [7:0]    gnt_n;
    logic [7:0]    cand;
    logic          pre_n;
    logic          found;
    logic          owner_req;
    logic          at_limit;
    logic [HW-1:0] hold_cnt, hold_n;

    // While the owner still requests, only the others are candidates (rotation).
    always_comb begin
        owner_req = (state == GRANT) && req[gnt_idx];
        at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        cand      = owner_req ? (req & ~gnt) : req;
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        scan  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            scan = ptr + 3'(i);
            if (!found && cand[scan]) begin
                win   = scan;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        pre_n   = 1'b0;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        if (!en) begin
            state_n = IDLE;
            gnt_n   = '0;
            idx_n   = '0;
            hold_n  = '0;
        end else if (!owner_req) begin
            // Covers both IDLE and an owner that has just released.
            if (found) begin
                state_n = GRANT;
                gnt_n   = 8'h01 << win;
                idx_n   = win;
                ptr_n   = win + 3'd1;
                hold_n  = '0;
            end else begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
                hold_n  = '0;
            end
        end else if (at_limit && found) begin
            state_n = GRANT;
            gnt_n   = 8'h01 << win;
            idx_n   = win;
            ptr_n   = win + 3'd1;
            hold_n  = '0;
            pre_n   = 1'b1;
        end else if ((MAX_HOLD != 0) && !at_limit) begin
            hold_n = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= |gnt_n;
            preempt   <= pre_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
        end
    end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: directed vector table, hand-written corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_req_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] gnt0, gnt4;
    logic [2:0] idx0, idx4;
    logic       val0, val4;
    logic       pre0, pre4;

    int n_cmp = 0;
    int n_bad = 0;

    req_arbiter_8 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .preempt(pre0)
    );

    req_arbiter_8 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .preempt(pre4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 = none), search start, cycles owned so far.
    typedef struct {
        int owner;
        int ptr;
        int held;
        bit pre;
    } m_t;

    m_t mdl[2];

    function automatic int search(logic [7:0] v, int from);
        for (int i = 0; i < 8; i++) begin
            int j;
            j = (from + i) % 8;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic m_t mstep(m_t s, int mh, logic en_i, logic [7:0] r);
        m_t n;
        int w;
        logic [7:0] others;
        n = s;
        n.pre = 1'b0;
        if (!en_i) begin
            n.owner = -1;
            n.held  = 0;
            return n;
        end
        if (s.owner < 0 || !r[s.owner]) begin
            w = search(r, s.ptr);
            if (w < 0) begin
                n.owner = -1;
                n.held  = 0;
            end else begin
                n.owner = w;
                n.ptr   = (w + 1) % 8;
                n.held  = 1;
            end
            return n;
        end
        others = r & ~(8'h01 << s.owner);
        if (mh != 0 && s.held >= mh && others != 8'h00) begin
            w = search(others, s.ptr);
            n.owner = w;
            n.ptr   = (w + 1) % 8;
            n.held  = 1;
            n.pre   = 1'b1;
        end else begin
            n.held = s.held + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) mdl[k] <= '{owner: -1, ptr: 0, held: 0, pre: 1'b0};
            else        mdl[k] <= mstep(mdl[k], (k == 0) ? 0 : 4, en, req);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] g, eg;
        logic [2:0] ix, ei;
        logic       v, p;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = gnt0; ix = idx0; v = val0; p = pre0; end
            else        begin g = gnt4; ix = idx4; v = val4; p = pre4; end
            eg = 8'h00;
            ei = 3'd0;
            if (mdl[k].owner >= 0) begin
                eg = 8'h01 << mdl[k].owner;
                ei = 3'(mdl[k].owner);
            end
            chk($sformatf("model%0d gnt", k), 32'(g), 32'(eg));
            chk($sformatf("model%0d gnt_idx", k), 32'(ix), 32'(ei));
            chk($sformatf("model%0d gnt_valid", k), 32'(v), 32'(mdl[k].owner >= 0));
            chk($sformatf("model%0d preempt", k), 32'(p), 32'(mdl[k].pre));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic chk_dut(input string name, input int k, input logic [7:0] eg,
                           input logic [2:0] ei, input logic ev, input logic ep);
        if (k == 0) begin
            chk({name, " gnt"}, 32'(gnt0), 32'(eg));
            chk({name, " idx"}, 32'(idx0), 32'(ei));
            chk({name, " valid"}, 32'(val0), 32'(ev));
            chk({name, " preempt"}, 32'(pre0), 32'(ep));
        end else begin
            chk({name, " gnt"}, 32'(gnt4), 32'(eg));
            chk({name, " idx"}, 32'(idx4), 32'(ei));
            chk({name, " valid"}, 32'(val4), 32'(ev));
            chk({name, " preempt"}, 32'(pre4), 32'(ep));
        end
    endtask

    // Called at a falling edge; reset pulse completes before the next rising edge.
    task automatic do_reset();
        req = 8'h00;
        en  = 1'b1;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic p);
        vec_t x;
        x.en = e; x.req = r; x.gnt = g; x.idx = i; x.valid = v; x.pre = p;
        vt.push_back(x);
    endtask

    initial begin
        // Expectations for the MAX_HOLD=4 instance, starting right after reset.
        add(1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h81, 8'h01, 0, 1, 0);
        add(1, 8'h81, 8'h01, 0, 1, 0);
        add(1, 8'h81, 8'h01, 0, 1, 0);
        add(1, 8'h81, 8'h01, 0, 1, 0);
        add(1, 8'h81, 8'h80, 7, 1, 1);
        add(1, 8'h81, 8'h80, 7, 1, 0);
        add(1, 8'h81, 8'h80, 7, 1, 0);
        add(1, 8'h81, 8'h80, 7, 1, 0);
        add(1, 8'h81, 8'h01, 0, 1, 1);
        add(1, 8'h81, 8'h01, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(1, 8'h01, 8'h01, 0, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h20, 8'h20, 5, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h08, 8'h08, 3, 1, 0);
        add(0, 8'h08, 8'h00, 0, 0, 0);
        add(0, 8'h08, 8'h00, 0, 0, 0);
        add(1, 8'h18, 8'h10, 4, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0, 0);

        rst_n = 1'b1;
        en    = 1'b1;
        req   = 8'hFF;
        #1 rst_n = 1'b0;
        #1;
        chk_dut("reset0 immediate", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_dut("reset4 immediate", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        chk_dut("reset4 held", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        chk_dut("reset0 held", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        req   = 8'h00;
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            en  = vt[i].en;
            req = vt[i].req;
            tick();
            chk_dut($sformatf("vec%0d", i), 1, vt[i].gnt, vt[i].idx, vt[i].valid, vt[i].pre);
        end

        // Fair rotation on the unlimited-hold instance.
        do_reset();
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            logic [7:0] eg;
            eg = 8'h01 << (i % 8);
            for (int c = 0; c < 3; c++) begin
                chk_dut($sformatf("rot owner%0d c%0d", i, c), 0, eg, 3'(i % 8), 1'b1, 1'b0);
                if (c < 2) tick();
            end
            req = 8'hFF & ~eg;
            tick();
            req = 8'hFF;
        end

        // Asynchronous reset while owner 6 holds.
        do_reset();
        req = 8'h40;
        tick();
        chk_dut("areset pre-owner", 1, 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'h41;
        #2 rst_n = 1'b0;
        #1;
        chk_dut("areset clear0", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_dut("areset clear4", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk_dut("areset regrant0", 0, 8'h01, 3'd0, 1'b1, 1'b0);
        chk_dut("areset regrant4", 1, 8'h01, 3'd0, 1'b1, 1'b0);

        // Randomized traffic: sticky request patterns so hold limits are exercised.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) req = req ^ (8'h01 << $urandom_range(0, 7));
            en = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
